// File: rtl/coproc_sequenciador.sv
// ---------------------------------------------------------------------------
// coproc_sequenciador
//
// Control unit that runs one matrix-ULA instruction at a time. It accepts an
// instruction, streams operand A (and B for binary opcodes) byte by byte from
// data memory into 200-bit operand registers, issues the opcode to the ULA,
// waits for ula_done, then streams the result back to memory.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only in IDLE)
//   instr_opcode        ULA opcode, 0011..1100 legal
//   instr_addr_a/b/c    operand A, operand B and result base addresses
//   instr_escalar       scalar operand for opcode 1000
//   mem_addr/rd/rdata   memory read port (rdata valid the cycle after rd)
//   mem_wr/wdata        memory write port
//   ula_opcode          opcode to ULA, 0000 outside EXEC/WAIT
//   ula_escalar         latched scalar
//   ula_matriz_a/b      operand registers
//   ula_resultado/done  ULA result and completion flag
//   busy                high in every state except IDLE
//   done                one-cycle pulse when an instruction completes
//   erro                one-cycle pulse (with done) on illegal opcode or
//                       ULA timeout
//
// Optional feature (macro CONTADOR_CICLOS_EN):
//   ciclos[15:0]        cycles from accept edge to DONE inclusive,
//                       saturating, updated at DONE and held until the next
// ---------------------------------------------------------------------------
module coproc_sequenciador #(
    parameter int MEM_AW      = 8,
    parameter int N_ELEM      = 25,
    parameter int ULA_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3:0]            instr_opcode,
    input  logic [MEM_AW-1:0]     instr_addr_a,
    input  logic [MEM_AW-1:0]     instr_addr_b,
    input  logic [MEM_AW-1:0]     instr_addr_c,
    input  logic [7:0]            instr_escalar,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic                  mem_wr,
    output logic [7:0]            mem_wdata,
    output logic [3:0]            ula_opcode,
    output logic [7:0]            ula_escalar,
    output logic [8*N_ELEM-1:0]   ula_matriz_a,
    output logic [8*N_ELEM-1:0]   ula_matriz_b,
    input  logic [8*N_ELEM-1:0]   ula_resultado,
    input  logic                  ula_done,
    output logic                  busy,
    output logic                  done,
`ifdef CONTADOR_CICLOS_EN
    output logic [15:0]           ciclos,
`endif
    output logic                  erro
);

    localparam int MAT_W = 8 * N_ELEM;
    localparam int K_W   = $clog2(N_ELEM + 1);
    localparam int T_W   = $clog2(ULA_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // A load phase runs k = 0..N_ELEM: N_ELEM read cycles plus one trailing
    // capture cycle for the last byte.
    localparam logic [K_W-1:0] K_LAST_LOAD  = K_W'(N_ELEM);
    localparam logic [K_W-1:0] K_LAST_STORE = K_W'(N_ELEM - 1);
    localparam logic [T_W-1:0] T_LAST       = T_W'(ULA_TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [T_W-1:0]    tmo_q, tmo_d;
    logic [3:0]        op_q, op_d;
    logic [MEM_AW-1:0] addr_a_q, addr_a_d;
    logic [MEM_AW-1:0] addr_b_q, addr_b_d;
    logic [MEM_AW-1:0] addr_c_q, addr_c_d;
    logic [7:0]        escalar_q, escalar_d;
    logic [MAT_W-1:0]  mat_a_q, mat_a_d;
    logic [MAT_W-1:0]  mat_b_q, mat_b_d;
    logic [MAT_W-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [K_W-1:0]    k_prev;

    function automatic logic op_legal(input logic [3:0] op);
        return (op >= 4'h3) && (op <= 4'hC);
    endfunction

    function automatic logic op_needs_b(input logic [3:0] op);
        return (op >= 4'h3) && (op <= 4'h5);
    endfunction

    // Determinant opcodes produce a single result byte.
    function automatic logic op_is_det(input logic [3:0] op);
        return op >= 4'h9;
    endfunction

    function automatic logic [MAT_W-1:0] put_byte(input logic [MAT_W-1:0] m,
                                                  input logic [K_W-1:0]   idx,
                                                  input logic [7:0]       b);
        logic [MAT_W-1:0] r;
        r = m;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx == K_W'(i)) r[8*i +: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [MAT_W-1:0] m,
                                            input logic [K_W-1:0]   idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx == K_W'(i)) b = m[8*i +: 8];
        end
        return b;
    endfunction

    // Read data arriving in load cycle k belongs to the address issued in k-1.
    assign k_prev = k_q - K_W'(1);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tmo_d     = tmo_q;
        op_d      = op_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        addr_c_d  = addr_c_q;
        escalar_d = escalar_q;
        mat_a_d   = mat_a_q;
        mat_b_d   = mat_b_q;
        res_d     = res_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d      = instr_opcode;
                    addr_a_d  = instr_addr_a;
                    addr_b_d  = instr_addr_b;
                    addr_c_d  = instr_addr_c;
                    escalar_d = instr_escalar;
                    k_d       = '0;
                    if (op_legal(instr_opcode)) begin
                        err_d   = 1'b0;
                        state_d = S_LOAD_A;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_LOAD_A: begin
                if (k_q != '0) mat_a_d = put_byte(mat_a_q, k_prev, mem_rdata);
                if (k_q == K_LAST_LOAD) begin
                    k_d     = '0;
                    state_d = op_needs_b(op_q) ? S_LOAD_B : S_EXEC;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            S_LOAD_B: begin
                if (k_q != '0) mat_b_d = put_byte(mat_b_q, k_prev, mem_rdata);
                if (k_q == K_LAST_LOAD) begin
                    k_d     = '0;
                    state_d = S_EXEC;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            S_EXEC: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end

            // ula_done wins over the timeout on the last allowed cycle.
            S_WAIT: begin
                if (ula_done) begin
                    res_d   = ula_resultado;
                    k_d     = '0;
                    state_d = S_STORE;
                end else if (tmo_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + T_W'(1);
                end
            end

            S_STORE: begin
                if (op_is_det(op_q) || (k_q == K_LAST_STORE)) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            S_DONE: begin
                err_d   = 1'b0;
                k_d     = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            tmo_q     <= '0;
            op_q      <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
            escalar_q <= '0;
            mat_a_q   <= '0;
            mat_b_q   <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            tmo_q     <= tmo_d;
            op_q      <= op_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            addr_c_q  <= addr_c_d;
            escalar_q <= escalar_d;
            mat_a_q   <= mat_a_d;
            mat_b_q   <= mat_b_d;
            res_q     <= res_d;
            err_q     <= err_d;
        end
    end

    // Memory port: address is base+k, wrapping naturally at MEM_AW bits.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 8'h00;
        case (state_q)
            S_LOAD_A: begin
                if (k_q != K_LAST_LOAD) begin
                    mem_rd   = 1'b1;
                    mem_addr = addr_a_q + MEM_AW'(k_q);
                end
            end
            S_LOAD_B: begin
                if (k_q != K_LAST_LOAD) begin
                    mem_rd   = 1'b1;
                    mem_addr = addr_b_q + MEM_AW'(k_q);
                end
            end
            S_STORE: begin
                mem_wr    = 1'b1;
                mem_addr  = addr_c_q + MEM_AW'(k_q);
                mem_wdata = get_byte(res_q, k_q);
            end
            default: ;
        endcase
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign erro         = (state_q == S_DONE) && err_q;
    assign ula_opcode   = ((state_q == S_EXEC) || (state_q == S_WAIT)) ? op_q : 4'h0;
    assign ula_escalar  = escalar_q;
    assign ula_matriz_a = mat_a_q;
    assign ula_matriz_b = mat_b_q;

`ifdef CONTADOR_CICLOS_EN
    // cnt_q holds the index of the current cycle counted from the accept
    // edge (1 in the first busy cycle), so in DONE it equals the total.
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ciclos_q, ciclos_d;

    always_comb begin
        cnt_d    = cnt_q;
        ciclos_d = ciclos_q;
        if (state_q == S_IDLE) begin
            if (instr_valid) cnt_d = 16'd1;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (state_q == S_DONE) ciclos_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 16'd0;
            ciclos_q <= 16'd0;
        end else begin
            cnt_q    <= cnt_d;
            ciclos_q <= ciclos_d;
        end
    end

    assign ciclos = ciclos_q;
`endif

endmodule

// File: tb/tb_coproc_sequenciador.sv
module tb_coproc_sequenciador;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [3:0]   instr_opcode;
    logic [7:0]   instr_addr_a, instr_addr_b, instr_addr_c, instr_escalar;
    logic [7:0]   mem_addr;
    logic         mem_rd, mem_wr;
    logic [7:0]   mem_rdata, mem_wdata;
    logic [3:0]   ula_opcode;
    logic [7:0]   ula_escalar;
    logic [199:0] ula_matriz_a, ula_matriz_b, ula_resultado;
    logic         ula_done;
    logic         busy, done, erro;
`ifdef CONTADOR_CICLOS_EN
    logic [15:0]  ciclos;
`endif

    coproc_sequenciador #(.MEM_AW(8), .N_ELEM(25), .ULA_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_addr_a(instr_addr_a),
        .instr_addr_b(instr_addr_b), .instr_addr_c(instr_addr_c),
        .instr_escalar(instr_escalar),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .ula_opcode(ula_opcode), .ula_escalar(ula_escalar),
        .ula_matriz_a(ula_matriz_a), .ula_matriz_b(ula_matriz_b),
        .ula_resultado(ula_resultado), .ula_done(ula_done),
        .busy(busy), .done(done),
`ifdef CONTADOR_CICLOS_EN
        .ciclos(ciclos),
`endif
        .erro(erro)
    );

    // ---------------- environment: memory and ULA ----------------
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load_img;

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    function automatic logic [199:0] ula_func(input logic [3:0] op, input logic [199:0] a,
                                              input logic [199:0] b, input logic [7:0] esc);
        logic [199:0] r;
        logic [7:0]   s;
        r = '0;
        s = 8'h00;
        for (int i = 0; i < 25; i++) begin
            case (op)
                4'h3: r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
                4'h4: r[8*i +: 8] = a[8*i +: 8] - b[8*i +: 8];
                4'h5: r[8*i +: 8] = 8'(a[8*i +: 8] * b[8*i +: 8]);
                4'h6: r[8*i +: 8] = a[8*((i % 5) * 5 + i / 5) +: 8];
                4'h7: r[8*i +: 8] = ~a[8*i +: 8];
                4'h8: r[8*i +: 8] = 8'(a[8*i +: 8] * esc);
                default: s = s + a[8*i +: 8];
            endcase
        end
        if (op >= 4'h9) r[7:0] = s ^ {4'h0, op};
        return r;
    endfunction

    // ULA raises done in the ula_lat-th cycle after EXEC (1 = first WAIT cycle).
    logic [7:0] ula_cnt;
    int         ula_lat;
    always @(posedge clk) begin
        if (ula_opcode == 4'h0) ula_cnt <= 8'd0;
        else if (ula_cnt != 8'hFF) ula_cnt <= ula_cnt + 8'd1;
    end
    assign ula_done      = (ula_opcode != 4'h0) && (int'(ula_cnt) == ula_lat);
    assign ula_resultado = ula_func(ula_opcode, ula_matriz_a, ula_matriz_b, ula_escalar);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // reference-model state: operand registers as seen by the ULA
    logic [199:0] m_a, m_b;
    int           last_ciclos;

    task automatic fill(input logic [7:0] base, input logic [7:0] val);
        for (int i = 0; i < 256; i++) img[i] = mem[i];
        for (int k = 0; k < 25; k++) img[8'(base + k)] = val;
        @(negedge clk);
        load_img = 1'b1;
        @(negedge clk);
        load_img = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] esc, input int lat,
                             input bit b2b, output int o_cyc, output logic o_err,
                             output int o_nwr);
        logic [7:0]   exp_rd[$];
        logic [7:0]   got_rd[$];
        logic [15:0]  exp_wr[$];
        logic [15:0]  got_wr[$];
        logic [199:0] ea, eb, r;
        int           e_cyc, nw, cyc, got_cyc, bad;
        logic         e_err, legal, need_b, overlap, busy_bad, err_stray, got_err;
        logic [3:0]   got_op;

        // reference model, derived from the instruction's rules
        legal  = (op >= 4'h3) && (op <= 4'hC);
        need_b = (op >= 4'h3) && (op <= 4'h5);
        ea = m_a;
        eb = m_b;
        if (!legal) begin
            e_cyc = 1;
            e_err = 1'b1;
        end else begin
            for (int k = 0; k < 25; k++) begin
                exp_rd.push_back(8'(a + k));
                ea[8*k +: 8] = mem[8'(a + k)];
            end
            if (need_b) begin
                for (int k = 0; k < 25; k++) begin
                    exp_rd.push_back(8'(b + k));
                    eb[8*k +: 8] = mem[8'(b + k)];
                end
            end
            e_cyc = 26 * (need_b ? 2 : 1) + 1;
            if (lat > 16) begin
                e_cyc = e_cyc + 16 + 1;
                e_err = 1'b1;
            end else begin
                r  = ula_func(op, ea, eb, esc);
                nw = (op >= 4'h9) ? 1 : 25;
                for (int k = 0; k < nw; k++) exp_wr.push_back({8'(c + k), r[8*k +: 8]});
                e_cyc = e_cyc + lat + nw + 1;
                e_err = 1'b0;
            end
        end

        ula_lat = lat;
        if (!b2b) @(negedge clk);
        instr_opcode  = op;
        instr_addr_a  = a;
        instr_addr_b  = b;
        instr_addr_c  = c;
        instr_escalar = esc;
        instr_valid   = 1'b1;
        chk("ready_at_accept", 200'(instr_ready), 200'(1'b1));
`ifdef CONTADOR_CICLOS_EN
        chk("ciclos_held", 200'(ciclos), 200'(last_ciclos));
`endif
        @(posedge clk);

        cyc = 0; got_cyc = -1; got_err = 1'b0; got_op = 4'h0;
        overlap = 1'b0; busy_bad = 1'b0; err_stray = 1'b0;
        while (cyc < 200 && got_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (mem_rd) got_rd.push_back(mem_addr);
            if (mem_wr) got_wr.push_back({mem_addr, mem_wdata});
            if (mem_rd && mem_wr) overlap = 1'b1;
            if (!busy || instr_ready) busy_bad = 1'b1;
            if (done) begin
                got_cyc     = cyc;
                got_err     = erro;
                got_op      = ula_opcode;
                instr_valid = 1'b0;
            end else begin
                if (erro) err_stray = 1'b1;
                // fields and valid are ignored while busy
                instr_opcode = 4'($urandom);
                instr_addr_a = 8'($urandom);
                instr_addr_c = 8'($urandom);
            end
        end
        instr_valid = 1'b0;
        if (got_cyc < 0) chk("done_seen", 200'(1'b0), 200'(1'b1));

        if (legal) m_a = ea;
        if (legal && need_b) m_b = eb;

        chk("done_cycle", 200'(got_cyc), 200'(e_cyc));
        chk("erro", 200'(got_err), 200'(e_err));
        chk("erro_stray", 200'(err_stray), 200'(1'b0));
        chk("ula_op_in_done", 200'(got_op), 200'(4'h0));
        chk("rd_wr_excl", 200'(overlap), 200'(1'b0));
        chk("busy_while_run", 200'(busy_bad), 200'(1'b0));

        bad = -1;
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            if (bad < 0 && got_rd[i] !== exp_rd[i]) bad = i;
        if (bad >= 0) chk("rd_addr", 200'(got_rd[bad]), 200'(exp_rd[bad]));
        else chk("rd_count", 200'(got_rd.size()), 200'(exp_rd.size()));

        bad = -1;
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            if (bad < 0 && got_wr[i] !== exp_wr[i]) bad = i;
        if (bad >= 0) chk("wr_addr_data", 200'(got_wr[bad]), 200'(exp_wr[bad]));
        else chk("wr_count", 200'(got_wr.size()), 200'(exp_wr.size()));

        @(negedge clk);
        chk("busy_after", 200'(busy), 200'(1'b0));
        chk("ready_after", 200'(instr_ready), 200'(1'b1));
        chk("matriz_a", ula_matriz_a, m_a);
        chk("matriz_b", ula_matriz_b, m_b);
`ifdef CONTADOR_CICLOS_EN
        chk("ciclos", 200'(ciclos), 200'(e_cyc));
        last_ciclos = e_cyc;
`endif
        o_cyc = got_cyc;
        o_err = got_err;
        o_nwr = got_wr.size();
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, c, esc;
        int         lat;
        logic       fill_en;
        logic [7:0] fa, fb;
        int         cyc;
        logic       err;
        int         nwr;
    } vec_t;

    localparam int NT = 12;
    vec_t tab [NT];

    initial begin
        int   g_cyc, g_nwr, hit, seen_done;
        logic g_err;
        logic [3:0] rop;
        int   rlat;

        //           op     a      b      c      esc   lat fill  fa     fb     cyc err nwr
        tab[0]  = '{4'h3, 8'h00, 8'h20, 8'h40, 8'h00, 1,  1'b1, 8'h02, 8'h03, 80, 1'b0, 25};
        tab[1]  = '{4'h6, 8'h00, 8'h20, 8'h60, 8'h00, 1,  1'b0, 8'h00, 8'h00, 54, 1'b0, 25};
        tab[2]  = '{4'h9, 8'hF0, 8'h20, 8'h7F, 8'h00, 1,  1'b1, 8'h11, 8'h03, 30, 1'b0, 1};
        tab[3]  = '{4'h0, 8'h00, 8'h20, 8'h40, 8'h00, 1,  1'b0, 8'h00, 8'h00, 1,  1'b1, 0};
        tab[4]  = '{4'h2, 8'h00, 8'h20, 8'h40, 8'h00, 1,  1'b0, 8'h00, 8'h00, 1,  1'b1, 0};
        tab[5]  = '{4'hD, 8'h00, 8'h20, 8'h40, 8'h00, 1,  1'b0, 8'h00, 8'h00, 1,  1'b1, 0};
        tab[6]  = '{4'hF, 8'h00, 8'h20, 8'h40, 8'h00, 1,  1'b0, 8'h00, 8'h00, 1,  1'b1, 0};
        tab[7]  = '{4'h3, 8'h00, 8'h20, 8'h40, 8'h00, 17, 1'b0, 8'h00, 8'h00, 70, 1'b1, 0};
        tab[8]  = '{4'h7, 8'h30, 8'h20, 8'hA0, 8'h00, 16, 1'b0, 8'h00, 8'h00, 69, 1'b0, 25};
        tab[9]  = '{4'h5, 8'h50, 8'hE8, 8'hC0, 8'h00, 3,  1'b0, 8'h00, 8'h00, 82, 1'b0, 25};
        tab[10] = '{4'h8, 8'h10, 8'h20, 8'h90, 8'h03, 2,  1'b0, 8'h00, 8'h00, 55, 1'b0, 25};
        tab[11] = '{4'hC, 8'h70, 8'h20, 8'hFF, 8'h00, 1,  1'b0, 8'h00, 8'h00, 30, 1'b0, 1};

        rst = 1'b1; instr_valid = 1'b0; instr_opcode = 4'h0;
        instr_addr_a = 8'h00; instr_addr_b = 8'h00; instr_addr_c = 8'h00;
        instr_escalar = 8'h00; load_img = 1'b0; ula_lat = 1;
        m_a = '0; m_b = '0; last_ciclos = 0;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        @(negedge clk);
        load_img = 1'b1;
        @(negedge clk);
        load_img = 1'b0;

        // reset state
        chk("rst_ready", 200'(instr_ready), 200'(1'b1));
        chk("rst_busy", 200'(busy), 200'(1'b0));
        chk("rst_done", 200'(done), 200'(1'b0));
        chk("rst_erro", 200'(erro), 200'(1'b0));
        chk("rst_mem_rd", 200'(mem_rd), 200'(1'b0));
        chk("rst_mem_wr", 200'(mem_wr), 200'(1'b0));
        chk("rst_ula_op", 200'(ula_opcode), 200'(4'h0));
        chk("rst_mem_addr", 200'(mem_addr), 200'(8'h00));
        chk("rst_matriz_a", ula_matriz_a, 200'(0));
        chk("rst_matriz_b", ula_matriz_b, 200'(0));
`ifdef CONTADOR_CICLOS_EN
        chk("rst_ciclos", 200'(ciclos), 200'(0));
`endif
        rst = 1'b0;

        // directed table
        for (int t = 0; t < NT; t++) begin
            if (tab[t].fill_en) begin
                fill(tab[t].a, tab[t].fa);
                fill(tab[t].b, tab[t].fb);
            end
            run_instr(tab[t].op, tab[t].a, tab[t].b, tab[t].c, tab[t].esc, tab[t].lat,
                      1'b0, g_cyc, g_err, g_nwr);
            chk($sformatf("tab%0d_cycles", t), 200'(g_cyc), 200'(tab[t].cyc));
            chk($sformatf("tab%0d_erro", t), 200'(g_err), 200'(tab[t].err));
            chk($sformatf("tab%0d_writes", t), 200'(g_nwr), 200'(tab[t].nwr));
            if (t == 0) chk("soma_byte_0x4C", 200'(mem[8'h4C]), 200'(8'h05));
        end

        // reset in the middle of STORE (k = 10)
        fill(8'h00, 8'h02);
        fill(8'h20, 8'h03);
        fill(8'h40, 8'h00);
        ula_lat = 1;
        @(negedge clk);
        instr_opcode = 4'h3; instr_addr_a = 8'h00; instr_addr_b = 8'h20;
        instr_addr_c = 8'h40; instr_escalar = 8'h00; instr_valid = 1'b1;
        @(posedge clk);
        hit = 0;
        for (int i = 0; i < 200 && hit == 0; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            if (mem_wr && mem_addr == 8'h4A) hit = 1;
        end
        chk("midrst_reach_store10", 200'(hit), 200'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_wr", 200'(mem_wr), 200'(1'b0));
        chk("midrst_done", 200'(done), 200'(1'b0));
        chk("midrst_busy", 200'(busy), 200'(1'b0));
        chk("midrst_ready", 200'(instr_ready), 200'(1'b1));
        chk("midrst_ula_op", 200'(ula_opcode), 200'(4'h0));
        chk("midrst_mem_addr", 200'(mem_addr), 200'(8'h00));
        chk("midrst_matriz_a", ula_matriz_a, 200'(0));
`ifdef CONTADOR_CICLOS_EN
        chk("midrst_ciclos", 200'(ciclos), 200'(0));
`endif
        rst = 1'b0;
        m_a = '0; m_b = '0; last_ciclos = 0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || mem_wr) seen_done = 1;
        end
        chk("midrst_quiet", 200'(seen_done), 200'(0));
        chk("midrst_partial_kept", 200'(mem[8'h4A]), 200'(8'h05));
        chk("midrst_no_more_wr", 200'(mem[8'h4B]), 200'(8'h00));

        // randomized instructions against the reference model
        for (int r = 0; r < 18; r++) begin
            if ($urandom_range(0, 7) == 0) rop = 4'($urandom);
            else rop = 4'($urandom_range(3, 12));
            if ($urandom_range(0, 5) == 0) rlat = $urandom_range(14, 18);
            else rlat = $urandom_range(1, 4);
            run_instr(rop, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), rlat,
                      (r > 0) && ($urandom_range(0, 1) == 1), g_cyc, g_err, g_nwr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coproc_sequenciador.md
Name: coproc_sequenciador

Overview:
- Control unit that sequences the matrix ULA for one instruction at a time.
- Accepts an instruction and fetches matrix A, and matrix B where needed, byte-by-byte from data memory into 200-bit operand registers.
- Issues the opcode to the ULA, waits for its done, then writes the result back to memory.
- Sits between the instruction front end and the ULA/data memory; the ULA is purely a datapath.

Parameters:
- MEM_AW, 8, data memory address width; all addresses wrap modulo 2^MEM_AW.
- N_ELEM, 25, elements per 5x5 matrix; byte i maps to bits [8*i +: 8].
- ULA_TIMEOUT, 16, max cycles in WAIT before an error is flagged.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  high only in IDLE
- instr_opcode  in  4  ULA opcode (0011..1100 legal)
- instr_addr_a  in  MEM_AW  base of matrix A
- instr_addr_b  in  MEM_AW  base of matrix B
- instr_addr_c  in  MEM_AW  base of result
- instr_escalar  in  8  scalar for opcode 1000
- mem_addr  out  MEM_AW  memory address
- mem_rd  out  1  read strobe; data returns on mem_rdata next cycle
- mem_rdata  in  8  read data
- mem_wr  out  1  write strobe
- mem_wdata  out  8  write data
- ula_opcode  out  4  to ULA; 0000 whenever not in EXEC/WAIT
- ula_escalar  out  8  latched scalar
- ula_matriz_a  out  200  operand A register
- ula_matriz_b  out  200  operand B register
- ula_resultado  in  200  ULA result
- ula_done  in  1  ULA done
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on instruction completion
- erro  out  1  one-cycle pulse: illegal opcode or ULA timeout

Behaviour:
- Reset: state IDLE. instr_ready=1. busy, done, erro, mem_rd, mem_wr = 0. ula_opcode=0000. Operand and result registers, counters and mem_addr = 0.
- Accept: in IDLE, instr_valid=1 sampled on an edge latches all instr_* fields. instr_ready is low from the next cycle.
- Illegal opcode (<0011 or >1100): go to DONE with erro=1 and done=1 in the same cycle. No memory access occurs.
- LOAD_A: 26 cycles. Cycles 0..24 drive mem_rd=1 and mem_addr=addr_a+k. Cycles 1..25 capture mem_rdata into byte k-1 of ula_matriz_a.
- LOAD_B: same as LOAD_A using addr_b into ula_matriz_b. Executed only for opcodes 0011, 0100, 0101. All other legal opcodes skip straight to EXEC, and ula_matriz_b keeps its previous value.
- EXEC: 1 cycle. Drive ula_opcode and ula_escalar; operands are stable.
- WAIT: hold ula_opcode. On ula_done=1, latch ula_resultado and go to STORE.
  - Timeout counter starts at 0 on entry to WAIT.
  - If ULA_TIMEOUT cycles pass without ula_done: go to DONE with erro=1 and done=1, with no writes.
- STORE: mem_wr=1, mem_addr=addr_c+k, mem_wdata=result byte k.
  - k=0..24 for opcodes 0011..1000.
  - Only k=0 (1 cycle) for determinant opcodes 1001..1100.
- DONE: 1 cycle, done=1, ula_opcode=0000. Then IDLE.
  - instr_valid is ignored outside IDLE.
  - A new instruction may be accepted on the first IDLE cycle.
- mem_rd and mem_wr are never high together.
- Address wrap: base+k computed modulo 2^MEM_AW.
- rst mid-operation: next cycle all outputs are at reset values and mem_wr=0. Partial writes are not undone, and no done pulse is produced.
- Reference latency (binary op, ULA done one edge after EXEC): done high in the 80th cycle after the accept edge (26+26+1+1+25, then DONE).

Optional Feature:
- Macro CONTADOR_CICLOS_EN.
- Defined: adds output ciclos[15:0]. It counts cycles from the accept edge to DONE inclusive and saturates at 16'hFFFF. The value is updated at DONE and held until the next DONE. Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Soma 0011; A all bytes 8'h02 at addr 0x00; B all 8'h03 at 0x20; C at 0x40; ULA model done after 1 edge -> 25 writes of 8'h05 to 0x40..0x58; done in cycle 80; busy low afterwards.
- Transposta 0110 -> no reads in 0x20 range, only 25 reads of A; done in cycle 54; ula_matriz_b unchanged.
- Det2 1001 with C at 0x7F -> exactly one write, at 0x7F; addr_a=0xF0 reads wrap 0xF0..0xFF then 0x00..0x08.
- Opcode 0000 -> erro and done pulse together 1 cycle after accept; mem_rd and mem_wr never asserted.
- ULA model never raises done -> erro pulse after 16 WAIT cycles; zero writes; instr_ready back to 1.
- rst asserted during STORE k=10 -> mem_wr=0 next cycle; no done; state IDLE; with CONTADOR_CICLOS_EN, ciclos=0.
